// File: rtl/basic_mux_ctrl.sv
// Sequencer for the project mux ena/addr inputs: every project change runs
// disable -> guard hold -> address change -> settle hold -> enable.
module basic_mux_ctrl #(
    parameter int unsigned NUM_PROJECTS  = 24,
    parameter int unsigned GUARD_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_ena,
    input  logic [4:0] req_addr,
    output logic       mux_ena,
    output logic [4:0] mux_addr,
    output logic       busy,
    output logic       err,
    input  logic       err_clr
);

    localparam int unsigned MAX_CYCLES = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SETTLE,
        ACTIVE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ena_nxt;
    logic [4:0]    addr_nxt;
    logic          pend_ena, pend_ena_nxt;
    logic [4:0]    pend_addr, pend_addr_nxt;
    logic          err_nxt;

    logic accept;
    logic addr_ok;
    logic bad_req;
    logic cnt_done;

    assign req_ready = (state == IDLE) || (state == ACTIVE);
    assign busy      = ~req_ready;
    assign accept    = req_valid & req_ready;
    assign addr_ok   = 32'(req_addr) < NUM_PROJECTS;
    assign bad_req   = accept & req_ena & ~addr_ok;
    // The counter is reloaded on every DRAIN/SETTLE entry, so 1 marks the last cycle.
    assign cnt_done  = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mux_ena   <= 1'b0;
            mux_addr  <= '0;
            pend_ena  <= 1'b0;
            pend_addr <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mux_ena   <= ena_nxt;
            mux_addr  <= addr_nxt;
            pend_ena  <= pend_ena_nxt;
            pend_addr <= pend_addr_nxt;
            err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        ena_nxt       = mux_ena;
        addr_nxt      = mux_addr;
        pend_ena_nxt  = pend_ena;
        pend_addr_nxt = pend_addr;

        case (state)
            IDLE: begin
                ena_nxt = 1'b0;
                if (accept && req_ena && addr_ok) begin
                    addr_nxt  = req_addr;
                    cnt_nxt   = CW'(SETTLE_CYCLES);
                    state_nxt = SETTLE;
                end
            end
            ACTIVE: begin
                if (accept && !(req_ena && !addr_ok) && !(req_ena && (req_addr == mux_addr))) begin
                    ena_nxt       = 1'b0;
                    pend_ena_nxt  = req_ena;
                    pend_addr_nxt = req_addr;
                    cnt_nxt       = CW'(GUARD_CYCLES);
                    state_nxt     = DRAIN;
                end
            end
            DRAIN: begin
                ena_nxt = 1'b0;
                if (cnt_done) begin
                    if (pend_ena) begin
                        addr_nxt  = pend_addr;
                        cnt_nxt   = CW'(SETTLE_CYCLES);
                        state_nxt = SETTLE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            SETTLE: begin
                if (cnt_done) begin
                    ena_nxt   = 1'b1;
                    state_nxt = ACTIVE;
                end else begin
                    ena_nxt = 1'b0;
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                ena_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Set has priority over clear; err never feeds back into the FSM.
    always_comb begin
        err_nxt = err;
        if (bad_req)
            err_nxt = 1'b1;
        else if (err_clr)
            err_nxt = 1'b0;
    end

endmodule

// File: tb/tb_basic_mux_ctrl.sv
// Directed bench for basic_mux_ctrl (GUARD=4, SETTLE=2, 24 projects) with
// immediate-assertion checks and a running address/enable invariant monitor.
module tb_basic_mux_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_ena;
    logic [4:0] req_addr;
    logic       mux_ena;
    logic [4:0] mux_addr;
    logic       busy;
    logic       err;
    logic       err_clr;

    int checks   = 0;
    int failures = 0;

    basic_mux_ctrl #(
        .NUM_PROJECTS (24),
        .GUARD_CYCLES (4),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_ena  (req_ena),
        .req_addr (req_addr),
        .mux_ena  (mux_ena),
        .mux_addr (mux_addr),
        .busy     (busy),
        .err      (err),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request in the current cycle; return one cycle later (T+1).
    task automatic req(input logic en, input logic [4:0] a);
        req_valid = 1'b1;
        req_ena   = en;
        req_addr  = a;
        step();
        req_valid = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Address may only move while the mux is disabled on both sides of the edge.
    logic       rst_at_edge = 1'b1;
    logic       p_ena       = 1'b0;
    logic [4:0] p_addr      = '0;
    always @(posedge clk) rst_at_edge = rst;
    always @(negedge clk) begin
        if (!rst_at_edge && (mux_ena || p_ena))
            chk("inv_addr_stable", 32'(mux_addr), 32'(p_addr));
        if (mux_ena)
            chk("inv_addr_range", 32'(mux_addr < 5'd24), 32'd1);
        p_ena  = mux_ena;
        p_addr = mux_addr;
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_ena = 1'b0; req_addr = '0; err_clr = 1'b0;
        steps(3);
        rst = 1'b0;
        step();
        chk("rst_ena",   32'(mux_ena),   32'd0);
        chk("rst_addr",  32'(mux_addr),  32'd0);
        chk("rst_err",   32'(err),       32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);

        // Enable from IDLE
        req(1'b1, 5'd5);
        chk("en_addr_t1",  32'(mux_addr),  32'd5);
        chk("en_ena_t1",   32'(mux_ena),   32'd0);
        chk("en_busy_t1",  32'(busy),      32'd1);
        chk("en_ready_t1", 32'(req_ready), 32'd0);
        step();
        chk("en_busy_t2",  32'(busy),      32'd1);
        chk("en_ready_t2", 32'(req_ready), 32'd0);
        chk("en_ena_t2",   32'(mux_ena),   32'd0);
        step();
        chk("en_ena_t3",   32'(mux_ena),   32'd1);
        chk("en_ready_t3", 32'(req_ready), 32'd1);

        // Switch 5 -> 17
        req(1'b1, 5'd17);
        chk("sw_ena_t1",  32'(mux_ena),  32'd0);
        chk("sw_addr_t1", 32'(mux_addr), 32'd5);
        steps(3);
        chk("sw_addr_t4", 32'(mux_addr), 32'd5);
        chk("sw_busy_t4", 32'(busy),     32'd1);
        step();
        chk("sw_addr_t5", 32'(mux_addr), 32'd17);
        chk("sw_ena_t5",  32'(mux_ena),  32'd0);
        step();
        chk("sw_ena_t6",  32'(mux_ena),  32'd0);
        step();
        chk("sw_ena_t7",  32'(mux_ena),  32'd1);
        chk("sw_rdy_t7",  32'(req_ready), 32'd1);

        // Disable from ACTIVE
        req(1'b0, 5'd0);
        chk("dis_ena_t1",  32'(mux_ena), 32'd0);
        chk("dis_busy_t1", 32'(busy),    32'd1);
        steps(3);
        chk("dis_busy_t4", 32'(busy),    32'd1);
        step();
        chk("dis_ready_t5", 32'(req_ready), 32'd1);
        chk("dis_ena_t5",   32'(mux_ena),   32'd0);
        chk("dis_addr_t5",  32'(mux_addr),  32'd17);

        // No-op disable in IDLE
        req(1'b0, 5'd3);
        chk("noop_idle_ready", 32'(req_ready), 32'd1);
        chk("noop_idle_ena",   32'(mux_ena),   32'd0);
        chk("noop_idle_addr",  32'(mux_addr),  32'd17);

        // Re-enable 17, then same-address request while ACTIVE
        req(1'b1, 5'd17);
        step();
        chk("reen_ena_t2", 32'(mux_ena), 32'd0);
        step();
        chk("reen_ena_t3", 32'(mux_ena), 32'd1);
        req(1'b1, 5'd17);
        chk("same_ena",   32'(mux_ena),   32'd1);
        chk("same_ready", 32'(req_ready), 32'd1);
        chk("same_addr",  32'(mux_addr),  32'd17);

        // Out-of-range while ACTIVE
        req(1'b1, 5'd31);
        chk("oor_act_err",   32'(err),       32'd1);
        chk("oor_act_ena",   32'(mux_ena),   32'd1);
        chk("oor_act_addr",  32'(mux_addr),  32'd17);
        chk("oor_act_ready", 32'(req_ready), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_act_err", 32'(err), 32'd0);

        // Out-of-range in IDLE (boundary 24), then clear vs set priority
        req(1'b0, 5'd0);
        steps(4);
        chk("oor_pre_ready", 32'(req_ready), 32'd1);
        req(1'b1, 5'd24);
        chk("oor_idle_err",   32'(err),       32'd1);
        chk("oor_idle_ena",   32'(mux_ena),   32'd0);
        chk("oor_idle_addr",  32'(mux_addr),  32'd17);
        chk("oor_idle_ready", 32'(req_ready), 32'd1);
        err_clr = 1'b1;
        req(1'b1, 5'd30);
        chk("set_wins_err", 32'(err), 32'd1);
        step();
        err_clr = 1'b0;
        chk("clr_alone_err", 32'(err), 32'd0);

        // Highest valid address
        req(1'b1, 5'd23);
        chk("max_addr_t1", 32'(mux_addr), 32'd23);
        chk("max_err_t1",  32'(err),      32'd0);
        steps(2);
        chk("max_ena_t3",  32'(mux_ena),  32'd1);

        // Held request through DRAIN/SETTLE with changing addresses
        req_valid = 1'b1; req_ena = 1'b1; req_addr = 5'd2;
        step();
        chk("hold_ena_t1", 32'(mux_ena), 32'd0);
        req_addr = 5'd9;  step();
        req_addr = 5'd11; step();
        req_addr = 5'd13; step();
        req_addr = 5'd15;
        chk("hold_addr_t4", 32'(mux_addr), 32'd23);
        step();
        chk("hold_addr_t5", 32'(mux_addr), 32'd2);
        req_addr = 5'd18; step();
        chk("hold_ena_t6", 32'(mux_ena), 32'd0);
        req_addr = 5'd20; step();
        chk("hold_ena_t7",   32'(mux_ena),   32'd1);
        chk("hold_ready_t7", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        chk("hold_acc_ena_t8",  32'(mux_ena),  32'd0);
        chk("hold_acc_busy_t8", 32'(busy),     32'd1);
        chk("hold_acc_addr_t8", 32'(mux_addr), 32'd2);
        steps(4);
        chk("hold_acc_addr_t12", 32'(mux_addr), 32'd20);
        steps(2);
        chk("hold_acc_ena_t14", 32'(mux_ena), 32'd1);

        // Reset in DRAIN cycle 2 with err set
        req(1'b1, 5'd28);
        chk("pre_rst_err", 32'(err), 32'd1);
        req(1'b1, 5'd3);
        step();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rdrain_ena",   32'(mux_ena),   32'd0);
        chk("rdrain_addr",  32'(mux_addr),  32'd0);
        chk("rdrain_err",   32'(err),       32'd0);
        chk("rdrain_ready", 32'(req_ready), 32'd1);
        steps(6);
        chk("rdrain_stay_ena",  32'(mux_ena),  32'd0);
        chk("rdrain_stay_addr", 32'(mux_addr), 32'd0);

        // Reset in ACTIVE; request during reset is ignored
        req(1'b1, 5'd7);
        steps(2);
        chk("ract_pre_ena", 32'(mux_ena), 32'd1);
        req(1'b1, 5'd25);
        chk("ract_pre_err", 32'(err), 32'd1);
        rst = 1'b1;
        req_valid = 1'b1; req_ena = 1'b1; req_addr = 5'd4;
        step();
        chk("ract_ena",   32'(mux_ena),   32'd0);
        chk("ract_addr",  32'(mux_addr),  32'd0);
        chk("ract_err",   32'(err),       32'd0);
        step();
        rst = 1'b0;
        req_valid = 1'b0;
        step();
        chk("ract_ready",   32'(req_ready), 32'd1);
        chk("ract_ign_addr", 32'(mux_addr), 32'd0);
        chk("ract_ign_busy", 32'(busy),     32'd0);

        steps(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/basic_mux_ctrl.md
# basic_mux_ctrl

Sequencer for the project multiplexer's `ena`/`addr` select inputs. It accepts select/deselect requests over a valid/ready handshake and drives `mux_ena` and `mux_addr` so that a project change always follows the same order: disable the current project, hold for a guard interval, change the address while disabled, hold for a settle interval, then enable. With this order, the address never changes while the mux is enabled, and the inputs of both the old and new project are zero during the switch. It sits between the chip-level configuration logic and the project mux.

## Interface

- `NUM_PROJECTS`, default 24. Number of populated mux slots. Valid addresses are 0..NUM_PROJECTS-1. Range 1..32.
- `GUARD_CYCLES`, default 4. Number of cycles `mux_ena` is held low, at the old address, before the address changes. Minimum 1.
- `SETTLE_CYCLES`, default 2. Number of cycles the new address is held with `mux_ena` low before enabling. Minimum 1.

- `clk`  in  1  Single clock for the block.
- `rst`  in  1  Reset. Synchronous and active-high.
- `req_valid`  in  1  A request is present.
- `req_ready`  out  1  The block can accept a request. A request transfers on `req_valid & req_ready`.
- `req_ena`  in  1  1 = select and enable `req_addr`. 0 = disable all projects.
- `req_addr`  in  5  Target project. Ignored when `req_ena=0`.
- `mux_ena`  out  1  Registered. Drives the mux `ena` input.
- `mux_addr`  out  5  Registered. Drives the mux `addr` input.
- `busy`  out  1  High while in DRAIN or SETTLE.
- `err`  out  1  Sticky flag. Set when a request carries an out-of-range address.
- `err_clr`  in  1  Clears `err`.

## Operation

States: IDLE, DRAIN, SETTLE, ACTIVE. `req_ready` = 1 in IDLE and ACTIVE, 0 in DRAIN and SETTLE (combinational from state). `busy` = inverse of `req_ready`.

Behaviour on an accepted request, by state:
- **IDLE** (`mux_ena`=0):
  - `req_ena`=1 with a valid address: load `mux_addr` with `req_addr`, load the counter with SETTLE_CYCLES, go to SETTLE.
  - `req_ena`=0: no-op.
  - Invalid address (`req_ena`=1, `req_addr` >= NUM_PROJECTS): set `err`. No state change.
- **ACTIVE** (`mux_ena`=1):
  - `req_ena`=1 and `req_addr`==`mux_addr`: no-op.
  - Invalid address: set `err`. The current project stays enabled.
  - Any other request: clear `mux_ena`, latch `pend_ena` and `pend_addr`, load the counter with GUARD_CYCLES, go to DRAIN.
- **DRAIN**: `mux_ena`=0 and `mux_addr` is held. The counter decrements. On expiry:
  - `pend_ena`=1: `mux_addr` <= `pend_addr`, counter <= SETTLE_CYCLES, go to SETTLE.
  - `pend_ena`=0: go to IDLE. `mux_addr` keeps the last value.
- **SETTLE**: `mux_ena`=0 and `mux_addr` is stable. The counter decrements. On expiry, `mux_ena` <= 1 and go to ACTIVE.

Other rules:
- `req_valid` is ignored in DRAIN and SETTLE. Requests are never queued.
- `err`: if set and `err_clr` occur in the same cycle, set wins. `err` never affects the FSM.
- The counter is wide enough for max(GUARD_CYCLES, SETTLE_CYCLES). It is free of wrap-around because it reloads on every entry to DRAIN or SETTLE.
- Reset values: state IDLE, `mux_ena`=0, `mux_addr`=0, `err`=0, `busy`=0, `req_ready`=1 (from the first cycle after `rst` deasserts). Requests are ignored while `rst`=1.
- A reset asserted mid-sequence (including in ACTIVE) forces `mux_ena`=0 at the next edge. No guard interval applies to a reset.

## Timing

Let T be the handshake cycle. All outputs change at clock edges.

- From IDLE:
  - `mux_addr` takes the new value at T+1.
  - `mux_ena` rises at T+1+SETTLE_CYCLES.
- From ACTIVE:
  - `mux_ena` falls at T+1.
  - `mux_addr` changes at T+1+GUARD_CYCLES.
  - `mux_ena` rises at T+1+GUARD_CYCLES+SETTLE_CYCLES.
  - `req_ready` returns high in that same cycle.
- Disable from ACTIVE: `mux_ena` falls at T+1. The block is in IDLE and `req_ready`=1 at T+1+GUARD_CYCLES.
- Invariant: `mux_addr` never changes in a cycle where `mux_ena`=1, and `mux_ena` is never 1 with an address >= NUM_PROJECTS.
- A new request can be accepted in the cycle `mux_ena` rises.

## Test plan

All scenarios use GUARD_CYCLES=4, SETTLE_CYCLES=2, NUM_PROJECTS=24.

- **Reset, then enable from IDLE.** Request en=1, addr=5, accepted at T. Required: `mux_addr`=5 at T+1; `mux_ena`=1 at T+3; `busy` high during T+1..T+2; `req_ready`=0 during T+1..T+2.
- **Switch projects.** From ACTIVE at addr 5, request addr=17 at T. Required: `mux_ena`=0 at T+1; `mux_addr`=5 through T+4; `mux_addr`=17 at T+5; `mux_ena`=1 at T+7. A checker confirms the address never changes while `mux_ena`=1.
- **Disable, and no-op requests.** From ACTIVE at addr 17, request en=0. Required: `mux_ena`=0 at T+1; IDLE at T+5; `mux_addr` stays 17. Then request en=0 in IDLE: no change. Then request addr=17 while ACTIVE: no disable pulse.
- **Out-of-range address.** Request addr=24 in IDLE, and addr=31 in ACTIVE. Required: `err`=1 at T+1, `mux_ena`/`mux_addr` unchanged. Then assert `err_clr` together with a new bad request: `err` stays 1. `err_clr` alone clears it.
- **Requests while busy.** Hold `req_valid`=1 with varying addresses through DRAIN and SETTLE. Required: only the first request takes effect; the held request is accepted in the cycle `mux_ena` rises.
- **Reset mid-sequence.** Assert `rst` in DRAIN cycle 2, and separately in ACTIVE. Required: next cycle `mux_ena`=0, `mux_addr`=0, `err`=0, state IDLE.
